// File: rtl/fwd_hazard_scoreboard_pkg.sv
// Shared types and sizing for the FP forwarding/hazard scoreboard.
package fwd_pkg;
    localparam int NREG   = 16;
    localparam int AW     = 4;
    localparam int NREAD  = 2;
    localparam int MAXLAT = 7;
    localparam int CW     = 3;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_M  = 2'b01,
        FWD_W  = 2'b10
    } fwd_sel_t;
endpackage

// File: rtl/fwd_hazard_scoreboard_if.sv
// Decode-side bundle: read addresses, issue request, M/W writeback info, results.
interface fwd_hazard_scoreboard_if;
    import fwd_pkg::*;

    logic [NREAD*AW-1:0] ra;
    logic                issue_valid;
    logic                issue_we;
    logic [AW-1:0]       issue_wa;
    logic [CW-1:0]       issue_lat;
    logic                flush;
    logic [AW-1:0]       WA3M;
    logic                RegWriteM;
    logic [AW-1:0]       WA3W;
    logic                RegWriteW;
    logic [NREAD*2-1:0]  fwd_sel;
    logic                stall;
    logic                busy;

    modport master (
        output ra, issue_valid, issue_we, issue_wa, issue_lat, flush,
               WA3M, RegWriteM, WA3W, RegWriteW,
        input  fwd_sel, stall, busy
    );

    modport slave (
        input  ra, issue_valid, issue_we, issue_wa, issue_lat, flush,
               WA3M, RegWriteM, WA3W, RegWriteW,
        output fwd_sel, stall, busy
    );
endinterface

// File: rtl/fwd_hazard_scoreboard_port_sel.sv
// Forward-source select for one read port; M is younger than W so it wins.
module fwd_port_sel
    import fwd_pkg::*;
(
    input  logic [AW-1:0] i_ra,
    input  logic [AW-1:0] i_wa3m,
    input  logic          i_regwrite_m,
    input  logic [AW-1:0] i_wa3w,
    input  logic          i_regwrite_w,
    output fwd_sel_t      o_fwd_sel
);
    always_comb begin
        o_fwd_sel = FWD_RF;
        if (i_regwrite_m && (i_ra == i_wa3m))
            o_fwd_sel = FWD_M;
        else if (i_regwrite_w && (i_ra == i_wa3w))
            o_fwd_sel = FWD_W;
    end
endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// Per-register in-flight write tracker with countdowns; raises RAW/WAW stalls
// and picks the operand forward source for each read port.
module fwd_hazard_scoreboard
    import fwd_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    fwd_hazard_scoreboard_if.slave  sb
);
    logic [NREG-1:0] r_pending;
    logic [CW-1:0]   r_cnt [NREG];

    fwd_sel_t        w_sel [NREAD];
    logic [NREAD-1:0] w_raw;
    logic            w_waw;
    logic            w_stall;
    logic            w_accept;

    generate
        for (genvar p = 0; p < NREAD; p++) begin : g_port
            fwd_port_sel u_sel (
                .i_ra         (sb.ra[p*AW +: AW]),
                .i_wa3m       (sb.WA3M),
                .i_regwrite_m (sb.RegWriteM),
                .i_wa3w       (sb.WA3W),
                .i_regwrite_w (sb.RegWriteW),
                .o_fwd_sel    (w_sel[p])
            );

            // A forwarded operand never stalls, even if the register is still pending.
            assign w_raw[p] = r_pending[sb.ra[p*AW +: AW]] && (w_sel[p] == FWD_RF);
            assign sb.fwd_sel[p*2 +: 2] = reset ? 2'b00 : w_sel[p];
        end
    endgenerate

    // Younger write must not retire at or before the one already in flight.
    assign w_waw = sb.issue_valid && sb.issue_we && r_pending[sb.issue_wa] &&
                   (r_cnt[sb.issue_wa] >= sb.issue_lat);

    assign w_stall  = sb.issue_valid && ((|w_raw) || w_waw);
    assign w_accept = sb.issue_valid && sb.issue_we && !w_stall && !sb.flush;

    assign sb.stall = !reset && w_stall;
    assign sb.busy  = !reset && (|r_pending);

    always_ff @(posedge clk) begin
        if (reset || sb.flush) begin
            r_pending <= '0;
            for (int r = 0; r < NREG; r++)
                r_cnt[r] <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                // A new accept overrides a counter expiring on the same edge.
                if (w_accept && (sb.issue_wa == AW'(r))) begin
                    r_pending[r] <= (sb.issue_lat != '0);
                    r_cnt[r]     <= sb.issue_lat;
                end else if (r_cnt[r] != '0) begin
                    r_cnt[r] <= r_cnt[r] - 1'b1;
                    if (r_cnt[r] == CW'(1))
                        r_pending[r] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Directed bench: forwarding priority, RAW/WAW stalls, flush, reset, expire+reissue.
module tb_fwd_hazard_scoreboard;
    import fwd_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    fwd_hazard_scoreboard_if sb();

    fwd_hazard_scoreboard dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        sb.ra          = {4'd15, 4'd15};
        sb.issue_valid = 1'b0;
        sb.issue_we    = 1'b0;
        sb.issue_wa    = 4'd0;
        sb.issue_lat   = 3'd0;
        sb.flush       = 1'b0;
        sb.WA3M        = 4'd0;
        sb.RegWriteM   = 1'b0;
        sb.WA3W        = 4'd0;
        sb.RegWriteW   = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic issue(input logic [3:0] wa, input logic [2:0] lat);
        sb.issue_valid = 1'b1;
        sb.issue_we    = 1'b1;
        sb.issue_wa    = wa;
        sb.issue_lat   = lat;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        sb.RegWriteM = 1'b1; sb.WA3M = 4'd15;
        step(); step(); #1;
        checks++;
        if (sb.fwd_sel !== 4'b0000 || sb.stall !== 1'b0 || sb.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got sel=%b stall=%b busy=%b want 0000 0 0",
                     sb.fwd_sel, sb.stall, sb.busy);
        end
        step();
        reset = 1'b0;
        idle();
        step(); #1;
        checks++;
        if (sb.busy !== 1'b0 || sb.stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got busy=%b stall=%b want 0 0", sb.busy, sb.stall);
        end
    endtask

    task automatic test_forwarding();
        step(); idle();
        sb.ra = {4'd15, 4'd3};
        sb.RegWriteM = 1'b1; sb.WA3M = 4'd3;
        sb.RegWriteW = 1'b1; sb.WA3W = 4'd3;
        sb.issue_valid = 1'b1;
        #1;
        checks++;
        if (sb.fwd_sel[1:0] !== 2'b01 || sb.stall !== 1'b0) begin
            failures++;
            $display("FAIL fwd_m_priority: got sel0=%b stall=%b want 01 0", sb.fwd_sel[1:0], sb.stall);
        end
        sb.RegWriteM = 1'b0;
        #1;
        checks++;
        if (sb.fwd_sel[1:0] !== 2'b10 || sb.stall !== 1'b0) begin
            failures++;
            $display("FAIL fwd_w: got sel0=%b stall=%b want 10 0", sb.fwd_sel[1:0], sb.stall);
        end
        sb.ra = {4'd7, 4'd4};
        sb.RegWriteM = 1'b1; sb.WA3M = 4'd7;
        sb.RegWriteW = 1'b1; sb.WA3W = 4'd4;
        #1;
        checks++;
        if (sb.fwd_sel !== 4'b0110) begin
            failures++;
            $display("FAIL fwd_two_ports: got %b want 0110", sb.fwd_sel);
        end
        sb.RegWriteW = 1'b0;
        sb.WA3M = 4'd8;
        #1;
        checks++;
        if (sb.fwd_sel !== 4'b0000) begin
            failures++;
            $display("FAIL fwd_no_match: got %b want 0000", sb.fwd_sel);
        end
        idle();
    endtask

    task automatic test_raw_stall();
        step(); idle();
        issue(4'd5, 3'd3);
        for (int t = 1; t <= 3; t++) begin
            step(); idle();
            sb.issue_valid = 1'b1;
            sb.ra = {4'd5, 4'd15};
            #1;
            checks++;
            if (sb.stall !== 1'b1) begin
                failures++;
                $display("FAIL raw_stall t%0d: got %b want 1", t, sb.stall);
            end
        end
        step(); idle();
        sb.issue_valid = 1'b1;
        sb.ra = {4'd5, 4'd15};
        #1;
        checks++;
        if (sb.stall !== 1'b0 || sb.busy !== 1'b0) begin
            failures++;
            $display("FAIL raw_release t4: got stall=%b busy=%b want 0 0", sb.stall, sb.busy);
        end
        idle();
        // forwarding hides a pending register from the RAW check
        issue(4'd5, 3'd3);
        step(); idle();
        sb.issue_valid = 1'b1;
        sb.ra = {4'd15, 4'd5};
        sb.RegWriteW = 1'b1; sb.WA3W = 4'd5;
        #1;
        checks++;
        if (sb.stall !== 1'b0 || sb.fwd_sel[1:0] !== 2'b10) begin
            failures++;
            $display("FAIL raw_forwarded: got stall=%b sel0=%b want 0 10", sb.stall, sb.fwd_sel[1:0]);
        end
        idle();
        for (int t = 0; t < 3; t++) step();
    endtask

    task automatic test_waw();
        step(); idle();
        issue(4'd2, 3'd5);
        step(); idle();
        issue(4'd2, 3'd2);
        #1;
        checks++;
        if (sb.stall !== 1'b1) begin
            failures++;
            $display("FAIL waw_shorter: got stall=%b want 1", sb.stall);
        end
        sb.issue_lat = 3'd6;
        #1;
        checks++;
        if (sb.stall !== 1'b0) begin
            failures++;
            $display("FAIL waw_longer: got stall=%b want 0", sb.stall);
        end
        step(); idle();
        issue(4'd2, 3'd6);
        #1;
        checks++;
        if (sb.stall !== 1'b1) begin
            failures++;
            $display("FAIL waw_cnt_is_6: lat6 probe got stall=%b want 1", sb.stall);
        end
        sb.issue_lat = 3'd7;
        #1;
        checks++;
        if (sb.stall !== 1'b0) begin
            failures++;
            $display("FAIL waw_cnt_below_7: lat7 probe got stall=%b want 0", sb.stall);
        end
        idle();
        for (int t = 3; t <= 8; t++) begin
            step(); #1;
            checks++;
            if (sb.busy !== (t <= 7)) begin
                failures++;
                $display("FAIL waw_busy t%0d: got %b want %b", t, sb.busy, (t <= 7));
            end
        end
    endtask

    task automatic test_flush();
        step(); idle(); issue(4'd1, 3'd7);
        step(); idle(); issue(4'd4, 3'd7);
        step(); idle(); issue(4'd7, 3'd7);
        step(); idle();
        issue(4'd10, 3'd3);
        sb.flush = 1'b1;
        #1;
        checks++;
        if (sb.busy !== 1'b1) begin
            failures++;
            $display("FAIL flush_before: got busy=%b want 1", sb.busy);
        end
        step(); idle();
        sb.issue_valid = 1'b1;
        sb.ra = {4'd4, 4'd1};
        #1;
        checks++;
        if (sb.busy !== 1'b0 || sb.stall !== 1'b0) begin
            failures++;
            $display("FAIL flush_after: got busy=%b stall=%b want 0 0", sb.busy, sb.stall);
        end
        sb.ra = {4'd15, 4'd10};
        #1;
        checks++;
        if (sb.stall !== 1'b0) begin
            failures++;
            $display("FAIL flush_no_accept: r10 stall=%b want 0", sb.stall);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        step(); idle(); issue(4'd9, 3'd6);
        step(); idle();
        step(); idle();
        step(); idle();
        reset = 1'b1;
        sb.issue_valid = 1'b1;
        sb.ra = {4'd11, 4'd9};
        sb.RegWriteW = 1'b1; sb.WA3W = 4'd11;
        #1;
        checks++;
        if (sb.fwd_sel !== 4'b0000 || sb.stall !== 1'b0 || sb.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_outputs: got sel=%b stall=%b busy=%b want 0000 0 0",
                     sb.fwd_sel, sb.stall, sb.busy);
        end
        step();
        reset = 1'b0;
        idle();
        sb.issue_valid = 1'b1;
        sb.ra = {4'd15, 4'd9};
        #1;
        checks++;
        if (sb.fwd_sel[1:0] !== 2'b00 || sb.stall !== 1'b0 || sb.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_after: got sel0=%b stall=%b busy=%b want 00 0 0",
                     sb.fwd_sel[1:0], sb.stall, sb.busy);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        step(); idle(); issue(4'd6, 3'd1);
        step(); idle(); issue(4'd6, 3'd4);
        #1;
        checks++;
        if (sb.stall !== 1'b0) begin
            failures++;
            $display("FAIL reissue_accept: got stall=%b want 0", sb.stall);
        end
        step(); idle();
        issue(4'd6, 3'd4);
        #1;
        checks++;
        if (sb.busy !== 1'b1 || sb.stall !== 1'b1) begin
            failures++;
            $display("FAIL reissue_cnt_is_4: got busy=%b stall=%b want 1 1", sb.busy, sb.stall);
        end
        sb.issue_lat = 3'd5;
        #1;
        checks++;
        if (sb.stall !== 1'b0) begin
            failures++;
            $display("FAIL reissue_cnt_below_5: got stall=%b want 0", sb.stall);
        end
        idle();
        for (int t = 3; t <= 6; t++) begin
            step(); #1;
            checks++;
            if (sb.busy !== (t <= 5)) begin
                failures++;
                $display("FAIL reissue_busy t%0d: got %b want %b", t, sb.busy, (t <= 5));
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        idle();
        test_reset();
        test_forwarding();
        test_raw_stall();
        test_waw();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
